// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Requests words from instruction memory
//            over a variable-latency req/ack handshake. Holds the current
//            instruction in IR with a one-entry prefetch buffer behind it.
//            A taken branch redirects the fetch and discards wrong-path data.
// Options  : FETCH_PERF_CNT_EN adds the fetch_count / bubble_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus8,
    output logic        ir_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    localparam logic [31:0] c_WORD_STEP = 32'd4;
    localparam logic [31:0] c_PC_AHEAD  = 32'd8;
    localparam logic [31:0] c_ALIGN_MSK = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_pending;     // request presented earlier and not yet acked
    logic [31:0] r_fetch_pc;
    logic [31:0] r_target;      // redirect address parked while flushing
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_ir_valid;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc;
    logic        r_buf_valid;

    logic        w_consume;
    logic        w_branch;
    logic        w_slot_free;
    logic        w_req;
    logic        w_ack;
    logic        w_discard;
    logic        w_accept;
    logic        w_to_ir;
    logic [31:0] w_target;

    assign w_consume   = r_ir_valid && !stall;
    assign w_branch    = w_consume && branch_taken;
    // A new request needs somewhere to land: IR empty, IR leaving, or buffer empty.
    assign w_slot_free = !r_ir_valid || w_consume || !r_buf_valid;
    // A request, once presented, stays up until acked even if the slot test changes.
    assign w_req       = !reset && (r_pending || ((r_state == ST_FETCH) && w_slot_free));
    // Acks without a live request (e.g. left over from before a reset) are dropped.
    assign w_ack       = imem_ack && w_req;
    assign w_discard   = (r_state == ST_FLUSH) || w_branch;
    assign w_accept    = w_ack && !w_discard;
    assign w_to_ir     = !r_ir_valid || (w_consume && !r_buf_valid);
    assign w_target    = branch_target & c_ALIGN_MSK;

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign IR_out      = r_ir_valid ? r_ir : NOP_INSTR;
    assign PC_out      = r_pc;
    assign PC_plus8    = r_pc + c_PC_AHEAD;
    assign ir_valid    = r_ir_valid;

    // Fetch FSM plus IR / prefetch-buffer datapath.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pending   <= 1'b0;
            r_fetch_pc  <= RESET_PC;
            r_target    <= RESET_PC;
            r_ir        <= NOP_INSTR;
            r_pc        <= RESET_PC;
            r_ir_valid  <= 1'b0;
            r_buf       <= NOP_INSTR;
            r_buf_pc    <= RESET_PC;
            r_buf_valid <= 1'b0;
        end else begin
            r_pending <= w_req && !imem_ack;

            if (w_branch) begin
                r_ir_valid  <= 1'b0;
                r_buf_valid <= 1'b0;
            end else begin
                // Consumption first; an accepted ack below may refill a slot.
                if (w_consume) begin
                    if (r_buf_valid) begin
                        r_ir        <= r_buf;
                        r_pc        <= r_buf_pc;
                        r_ir_valid  <= 1'b1;
                        r_buf_valid <= 1'b0;
                    end else begin
                        r_ir_valid  <= 1'b0;
                    end
                end
                if (w_accept) begin
                    if (w_to_ir) begin
                        r_ir        <= imem_rdata;
                        r_pc        <= r_fetch_pc;
                        r_ir_valid  <= 1'b1;
                    end else begin
                        r_buf       <= imem_rdata;
                        r_buf_pc    <= r_fetch_pc;
                        r_buf_valid <= 1'b1;
                    end
                end
            end

            case (r_state)
                ST_FETCH: begin
                    if (w_branch) begin
                        // Keep the address on the bus until the in-flight request completes.
                        if (w_req && !imem_ack) begin
                            r_state  <= ST_FLUSH;
                            r_target <= w_target;
                        end else begin
                            r_fetch_pc <= w_target;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= r_fetch_pc + c_WORD_STEP;
                    end
                end
                ST_FLUSH: begin
                    if (w_ack) begin
                        r_fetch_pc <= r_target;
                        r_state    <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    // Count delivered instructions and idle decode cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_fetch_count  <= 32'd0;
            r_bubble_count <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (!r_ir_valid && !stall) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic [31:0] PC_plus8;
    logic        ir_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    fetch_unit dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .IR_out        (IR_out),
        .PC_out        (PC_out),
        .PC_plus8      (PC_plus8),
        .ir_valid      (ir_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
`endif
    );

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        int          wt;
        logic        stray;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl[$];
    int          errors = 0;
    int          checks = 0;
    int          mem_cnt = 0;
    logic        obs_req;
    logic [31:0] obs_addr;

    // Memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic st, input logic br, input logic [31:0] tgt, input int wt,
                     input logic stray, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep);
        vec_t r;
        r.st = st; r.br = br; r.tgt = tgt; r.wt = wt; r.stray = stray;
        r.e_req = er; r.e_addr = ea; r.e_val = ev; r.e_pc = ep;
        tbl.push_back(r);
    endtask

    // One clock: drive inputs, let the memory answer, advance past the edge.
    // Memory acks once a request has been up for more than 'wt' cycles.
    task automatic do_cycle(input logic st, input logic br, input logic [31:0] tgt,
                            input int wt, input logic stray);
        stall = st; branch_taken = br; branch_target = tgt;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (imem_req) begin
            if (mem_cnt >= wt) begin
                imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); mem_cnt = 0;
            end else begin
                imem_ack = 1'b0; imem_rdata = 32'h0; mem_cnt++;
            end
        end else begin
            mem_cnt    = 0;
            imem_ack   = stray;
            imem_rdata = stray ? 32'hDEAD_BEEF : 32'h0;
        end
        @(posedge CLOCK_50);
        #1;
        imem_ack = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic e_val, input logic [31:0] e_pc);
        check32({tag, " ir_valid"}, {31'b0, ir_valid}, {31'b0, e_val});
        check32({tag, " IR_out"}, IR_out, e_val ? mem_word(e_pc) : NOP);
        if (e_val) begin
            check32({tag, " PC_out"}, PC_out, e_pc);
            check32({tag, " PC_plus8"}, PC_plus8, e_pc + 32'd8);
        end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

        //  st br tgt           wt stray  req addr          val pc
        v(0, 0, 32'h0,         0, 0,     1, 32'h00,        1, 32'h00);
        v(0, 0, 32'h0,         0, 0,     1, 32'h04,        1, 32'h04);
        v(0, 0, 32'h0,         0, 0,     1, 32'h08,        1, 32'h08);
        v(0, 0, 32'h0,         0, 0,     1, 32'h0C,        1, 32'h0C);
        v(0, 0, 32'h0,         0, 0,     1, 32'h10,        1, 32'h10);
        v(1, 0, 32'h0,         0, 0,     1, 32'h14,        1, 32'h10);
        v(1, 0, 32'h0,         0, 0,     0, 32'h0,         1, 32'h10);
        v(1, 0, 32'h0,         0, 1,     0, 32'h0,         1, 32'h10);
        v(1, 0, 32'h0,         0, 0,     0, 32'h0,         1, 32'h10);
        v(1, 0, 32'h0,         0, 0,     0, 32'h0,         1, 32'h10);
        v(0, 0, 32'h0,         0, 0,     1, 32'h18,        1, 32'h14);
        v(0, 0, 32'h0,         0, 0,     1, 32'h1C,        1, 32'h18);
        v(0, 0, 32'h0,         2, 0,     1, 32'h20,        1, 32'h1C);
        v(0, 1, 32'h100,       2, 0,     1, 32'h20,        0, 32'h0);
        v(0, 0, 32'h0,         2, 0,     1, 32'h20,        0, 32'h0);
        v(0, 0, 32'h0,         0, 0,     1, 32'h100,       1, 32'h100);
        v(0, 0, 32'h0,         0, 0,     1, 32'h104,       1, 32'h104);
        v(0, 1, 32'h200,       0, 0,     1, 32'h108,       0, 32'h0);
        v(0, 0, 32'h0,         0, 0,     1, 32'h200,       1, 32'h200);
        v(1, 1, 32'h300,       0, 0,     1, 32'h204,       1, 32'h200);
        v(0, 0, 32'h0,         0, 0,     1, 32'h208,       1, 32'h204);
        v(0, 0, 32'h0,         0, 0,     1, 32'h20C,       1, 32'h208);
        v(0, 1, 32'hFFFF_FFFE, 0, 0,     1, 32'h210,       0, 32'h0);
        v(0, 0, 32'h0,         0, 0,     1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        v(0, 0, 32'h0,         0, 0,     1, 32'h00,        1, 32'h00);
        v(0, 0, 32'h0,         3, 0,     1, 32'h04,        0, 32'h0);
        v(0, 0, 32'h0,         3, 0,     1, 32'h04,        0, 32'h0);
        v(0, 0, 32'h0,         3, 0,     1, 32'h04,        0, 32'h0);
        v(0, 0, 32'h0,         3, 0,     1, 32'h04,        1, 32'h04);
        v(0, 0, 32'h0,         3, 0,     1, 32'h08,        0, 32'h0);
        v(0, 0, 32'h0,         3, 0,     1, 32'h08,        0, 32'h0);
        v(0, 0, 32'h0,         3, 0,     1, 32'h08,        0, 32'h0);
        v(0, 0, 32'h0,         3, 0,     1, 32'h08,        1, 32'h08);

        @(posedge CLOCK_50);
        #1;
        do_cycle(0, 0, 32'h0, 0, 0);
        do_cycle(0, 0, 32'h0, 0, 0);
        check32("reset imem_req", {31'b0, obs_req}, 32'h0);
        check32("reset imem_addr", imem_addr, 32'h0);
        check32("reset PC_out", PC_out, 32'h0);
        check32("reset PC_plus8", PC_plus8, 32'h8);
        check_outputs("reset", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check32("reset fetch_count", fetch_count, 32'h0);
        check32("reset bubble_count", bubble_count, 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].wt, tbl[i].stray);
            check32($sformatf("row%0d imem_req", i), {31'b0, obs_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                check32($sformatf("row%0d imem_addr", i), obs_addr, tbl[i].e_addr);
            check_outputs($sformatf("row%0d", i), tbl[i].e_val, tbl[i].e_pc);
`ifdef FETCH_PERF_CNT_EN
            if (i == 16) begin
                check32("fetch_count", fetch_count, 32'd10);
                check32("bubble_count", bubble_count, 32'd3);
            end
`endif
        end

        // Reset while a request to 0x0C is outstanding; a stray ack is ignored.
        do_cycle(0, 0, 32'h0, 3, 0);
        check32("midrst pending req", {31'b0, obs_req}, 32'h1);
        check32("midrst pending addr", obs_addr, 32'h0C);
        reset = 1'b1;
        do_cycle(0, 0, 32'h0, 3, 1);
        check32("midrst imem_req", {31'b0, obs_req}, 32'h0);
        check32("midrst imem_addr", imem_addr, 32'h0);
        check32("midrst PC_out", PC_out, 32'h0);
        check_outputs("midrst", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check32("midrst fetch_count", fetch_count, 32'h0);
`endif
        reset = 1'b0;
        mem_cnt = 0;
        do_cycle(0, 0, 32'h0, 0, 0);
        check32("postrst addr0", obs_addr, 32'h0);
        check_outputs("postrst0", 1'b1, 32'h0);
        do_cycle(0, 0, 32'h0, 0, 0);
        check32("postrst addr1", obs_addr, 32'h4);
        check_outputs("postrst1", 1'b1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
